// File: rtl/clock_gate_pkg.sv
// Shared definitions for the clock-gate handshake: controller states,
// gate enable shift-register depth and the shared counter width.
package clock_gate_pkg;

  localparam int unsigned GATE_DEPTH = 4;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_RUN,
    ST_DRAIN,
    ST_COOL
  } wake_state_t;

endpackage

// File: rtl/clock_wake_ctrl.sv
// Initiator side of the clock-gate handshake: wakes the gated clock on a job
// request, launches the core, and holds the clock for an idle window after done.
module clock_wake_ctrl
  import clock_gate_pkg::*;
#(
  parameter int unsigned IDLE_HOLD    = 8,
  parameter int unsigned WAKE_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic start_in,
  input  logic done_i,
  output logic clk_en,
  output logic clk_end,
  output logic job_go,
  output logic busy,
  output logic wake_err
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_HOLD);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(GATE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  wake_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_d, clk_end_d, job_go_d, wake_err_d;
  logic             handshake;

  assign handshake = req_valid && req_ready;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      clk_en    <= 1'b0;
      clk_end   <= 1'b0;
      job_go    <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      wake_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_en    <= clk_en_d;
      clk_end   <= clk_end_d;
      job_go    <= job_go_d;
      req_ready <= (state_d == ST_OFF) || (state_d == ST_DRAIN);
      busy      <= (state_d != ST_OFF);
      wake_err  <= wake_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_en_d   = 1'b0;
    clk_end_d  = 1'b0;
    job_go_d   = 1'b0;
    wake_err_d = wake_err;
    unique case (state_q)
      ST_OFF: begin
        if (handshake) begin
          clk_en_d = 1'b1;
          cnt_d    = WAKE_LOAD;
          state_d  = ST_WAKE;
        end
      end
      ST_WAKE: begin
        // Timeout fires on the edge whose decrement would reach zero,
        // so WAKE lasts at most WAKE_TIMEOUT cycles; start_in has priority.
        if (start_in) begin
          job_go_d = 1'b1;
          state_d  = ST_RUN;
        end else if (cnt_q <= CNT_ONE) begin
          wake_err_d = 1'b1;
          clk_end_d  = 1'b1;
          cnt_d      = COOL_LOAD;
          state_d    = ST_COOL;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (done_i) begin
          cnt_d   = IDLE_LOAD;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          job_go_d = 1'b1;
          state_d  = ST_RUN;
        end else if (cnt_q == '0) begin
          clk_end_d = 1'b1;
          cnt_d     = COOL_LOAD;
          state_d   = ST_COOL;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_COOL: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_wake_ctrl.sv
// Self-checking bench for clock_wake_ctrl: two instances (long idle hold, and
// zero idle hold with a short wake timeout) checked cycle by cycle.
module tb_clock_wake_ctrl;

  typedef logic [5:0] out_t; // {clk_en, clk_end, job_go, req_ready, busy, wake_err}

  logic clk = 1'b0;
  logic rst;

  logic req_valid_a = 1'b0, start_a = 1'b0, done_a = 1'b0;
  logic ready_a, clk_en_a, clk_end_a, job_go_a, busy_a, err_a;
  logic req_valid_b = 1'b0, start_b = 1'b0, done_b = 1'b0;
  logic ready_b, clk_en_b, clk_end_b, job_go_b, busy_b, err_b;

  int   checks = 0;
  int   passed = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  clock_wake_ctrl #(.IDLE_HOLD(4), .WAKE_TIMEOUT(16)) dut_a (
    .clk_i(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(ready_a),
    .start_in(start_a), .done_i(done_a), .clk_en(clk_en_a), .clk_end(clk_end_a),
    .job_go(job_go_a), .busy(busy_a), .wake_err(err_a)
  );

  clock_wake_ctrl #(.IDLE_HOLD(0), .WAKE_TIMEOUT(3)) dut_b (
    .clk_i(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(ready_b),
    .start_in(start_b), .done_i(done_b), .clk_en(clk_en_b), .clk_end(clk_end_b),
    .job_go(job_go_b), .busy(busy_b), .wake_err(err_b)
  );

  function automatic out_t outs_a();
    return {clk_en_a, clk_end_a, job_go_a, ready_a, busy_a, err_a};
  endfunction

  function automatic out_t outs_b();
    return {clk_en_b, clk_end_b, job_go_b, ready_b, busy_b, err_b};
  endfunction

  function automatic out_t mk(bit en, bit ce, bit go, bit rd, bit bz, bit er);
    return {en, ce, go, rd, bz, er};
  endfunction

  task automatic test_reset();
    out_t got, want;
    rst = 1'b0;
    #1 rst = 1'b1;
    req_valid_a = 1'b1;
    #2;
    exp_q.push_back('0);
    got = outs_a(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL reset_a got=%b want=%b", got, want);
    else passed++;
    exp_q.push_back('0);
    got = outs_b(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL reset_b got=%b want=%b", got, want);
    else passed++;
    @(negedge clk) rst = 1'b0;
    // req_valid held through the first edge must not be accepted: ready was 0
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    got = outs_a(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL reset_release_a got=%b want=%b", got, want);
    else passed++;
    got = outs_b(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL reset_release_b got=%b want=%b", got, want);
    else passed++;
  endtask

  task automatic test_single_job();
    out_t got, want;
    for (int t = 0; t <= 32; t++) begin
      req_valid_a = (t == 0);
      start_a     = (t == 5);
      done_a      = (t == 2 || t == 20 || t == 27 || t == 31);
      exp_q.push_back(mk(t == 0, t == 25, t == 5, (t >= 20 && t <= 24) || t >= 30, t < 30, 1'b0));
      @(posedge clk); #1;
      got = outs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL single_job t=%0d got=%b want=%b", t, got, want);
      else passed++;
    end
    req_valid_a = 1'b0; start_a = 1'b0; done_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_t got, want;
    for (int t = 0; t <= 29; t++) begin
      req_valid_a = (t == 12);
      if (t == 0) req_valid_a = 1'b1;
      start_a = (t == 3);
      done_a  = (t == 10 || t == 18);
      exp_q.push_back(mk(t == 0, t == 23, t == 3 || t == 12,
                         (t >= 10 && t <= 11) || (t >= 18 && t <= 22) || t >= 28,
                         t < 28, 1'b0));
      @(posedge clk); #1;
      got = outs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL back_to_back t=%0d got=%b want=%b", t, got, want);
      else passed++;
    end
    req_valid_a = 1'b0; start_a = 1'b0; done_a = 1'b0;
  endtask

  task automatic test_drain_collision();
    out_t got, want;
    for (int t = 0; t <= 25; t++) begin
      req_valid_a = (t == 0 || t == 11);
      start_a     = (t == 2);
      done_a      = (t == 6 || t == 14);
      exp_q.push_back(mk(t == 0, t == 19, t == 2 || t == 11,
                         (t >= 6 && t <= 10) || (t >= 14 && t <= 18) || t >= 24,
                         t < 24, 1'b0));
      @(posedge clk); #1;
      got = outs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL drain_collision t=%0d got=%b want=%b", t, got, want);
      else passed++;
    end
    req_valid_a = 1'b0; start_a = 1'b0; done_a = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    out_t got, want;
    for (int t = 0; t <= 3; t++) begin
      req_valid_a = (t == 0);
      start_a     = (t == 3);
      exp_q.push_back(mk(t == 0, 0, t == 3, 0, 1, 0));
      @(posedge clk); #1;
      got = outs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL mid_run_pre t=%0d got=%b want=%b", t, got, want);
      else passed++;
    end
    req_valid_a = 1'b0; start_a = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.push_back('0);
    got = outs_a(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL mid_run_async got=%b want=%b", got, want);
    else passed++;
    @(negedge clk) rst = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    got = outs_a(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL mid_run_release got=%b want=%b", got, want);
    else passed++;
    test_single_job();
  endtask

  task automatic test_timeout();
    out_t got, want;
    for (int t = 0; t <= 21; t++) begin
      req_valid_b = (t == 0 || t == 10);
      start_b     = (t == 12);
      done_b      = (t == 1 || t == 5 || t == 14);
      exp_q.push_back(mk(t == 0 || t == 10, t == 3 || t == 15, t == 12,
                         (t >= 8 && t < 10) || t == 14 || t >= 20,
                         t < 8 || (t >= 10 && t < 20), t >= 3));
      @(posedge clk); #1;
      got = outs_b(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL timeout t=%0d got=%b want=%b", t, got, want);
      else passed++;
    end
    req_valid_b = 1'b0; start_b = 1'b0; done_b = 1'b0;
  endtask

  task automatic test_start_on_timeout();
    out_t got, want;
    @(negedge clk) rst = 1'b1;
    #1;
    exp_q.push_back('0);
    got = outs_b(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL err_cleared got=%b want=%b", got, want);
    else passed++;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t <= 12; t++) begin
      req_valid_b = (t == 0);
      start_b     = (t == 3);
      done_b      = (t == 5);
      exp_q.push_back(mk(t == 0, t == 6, t == 3, t == 5 || t >= 11, t < 11, 1'b0));
      @(posedge clk); #1;
      got = outs_b(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL start_on_timeout t=%0d got=%b want=%b", t, got, want);
      else passed++;
    end
    req_valid_b = 1'b0; start_b = 1'b0; done_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_drain_collision();
    test_reset_mid_run();
    test_timeout();
    test_start_on_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
